// File: rtl/chip8_mem_arbiter.sv
// Round-robin arbiter sharing one registered memory port among NUM_PORTS requesters.
// Each port owns a one-deep request slot; completions come back in issue order via a tag pipeline.
module chip8_mem_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_PORTS-1:0]             req_valid_in,
    output logic [NUM_PORTS-1:0]             req_ready_out,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [NUM_PORTS-1:0]             req_we_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data_in,
    output logic [NUM_PORTS-1:0]             resp_valid_out,
    output logic [DATA_WIDTH-1:0]            resp_data_out,
    output logic [ADDR_WIDTH-1:0]            mem_addr_out,
    output logic                             mem_we_out,
    output logic [DATA_WIDTH-1:0]            mem_data_out,
    input  logic [DATA_WIDTH-1:0]            mem_data_in
);
    localparam int unsigned PW = $clog2(NUM_PORTS);

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] port;
    } tag_t;

    logic [NUM_PORTS-1:0]            r_pending;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] r_slot_addr;
    logic [NUM_PORTS-1:0]            r_slot_we;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_slot_data;
    logic [PW-1:0]                   r_last_grant;
    // Stage 0 travels alongside mem_*; stages 1..LATENCY are the memory latency.
    tag_t [LATENCY:0]                r_tags;
    logic [ADDR_WIDTH-1:0]           r_mem_addr;
    logic                            r_mem_we;
    logic [DATA_WIDTH-1:0]           r_mem_data;

    logic [NUM_PORTS-1:0]            w_accept;
    logic                            w_grant_vld;
    logic [PW-1:0]                   w_grant_idx;
    logic [NUM_PORTS-1:0]            w_grant_oh;
    tag_t                            w_new_tag;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] last, input int unsigned offs);
        return PW'((32'(last) + offs) % NUM_PORTS);
    endfunction

    assign req_ready_out = ~r_pending;
    assign w_accept      = req_valid_in & ~r_pending;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            if (!w_grant_vld && r_pending[rr_idx(r_last_grant, i)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = rr_idx(r_last_grant, i);
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        if (w_grant_vld) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
        w_new_tag.vld  = w_grant_vld;
        w_new_tag.port = w_grant_idx;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pending    <= '0;
            r_slot_addr  <= '0;
            r_slot_we    <= '0;
            r_slot_data  <= '0;
            r_last_grant <= PW'(NUM_PORTS - 1);
            r_tags       <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_data   <= '0;
        end else begin
            // A granted port is never accepting in the same cycle, so set and clear cannot collide.
            r_pending <= (r_pending & ~w_grant_oh) | w_accept;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (w_accept[i +: 1] == 1'b1) begin
                    r_slot_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_slot_we[i +: 1]                       <= req_we_in[i +: 1];
                    r_slot_data[i*DATA_WIDTH +: DATA_WIDTH] <= req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            r_tags   <= {r_tags[LATENCY-1:0], w_new_tag};
            r_mem_we <= 1'b0;
            if (w_grant_vld) begin
                r_mem_addr   <= r_slot_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_mem_we     <= r_slot_we[w_grant_idx];
                r_mem_data   <= r_slot_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                r_last_grant <= w_grant_idx;
            end
        end
    end

    always_comb begin
        resp_valid_out = '0;
        if (r_tags[LATENCY].vld) begin
            resp_valid_out[r_tags[LATENCY].port] = 1'b1;
        end
    end

    assign resp_data_out = mem_data_in;
    assign mem_addr_out  = r_mem_addr;
    assign mem_we_out    = r_mem_we;
    assign mem_data_out  = r_mem_data;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter: a table of single-port transactions plus
// hand sequences for contention, fairness, write/read, reset in flight and backpressure.
module tb_chip8_mem_arbiter;
    localparam int NP  = 4;
    localparam int AW  = 13;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [NP-1:0]     req_valid_in, req_ready_out, req_we_in, resp_valid_out;
    logic [NP*AW-1:0]  req_addr_in;
    logic [NP*DW-1:0]  req_data_in;
    logic [DW-1:0]     resp_data_out, mem_data_out, mem_data_in;
    logic [AW-1:0]     mem_addr_out;
    logic              mem_we_out;

    int n_checks = 0;
    int n_pass   = 0;

    chip8_mem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LATENCY   (LAT)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req_addr_in   (req_addr_in),
        .req_we_in     (req_we_in),
        .req_data_in   (req_data_in),
        .resp_valid_out(resp_valid_out),
        .resp_data_out (resp_data_out),
        .mem_addr_out  (mem_addr_out),
        .mem_we_out    (mem_we_out),
        .mem_data_out  (mem_data_out),
        .mem_data_in   (mem_data_in)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural memory: data for the address seen in cycle n appears in cycle n+LAT.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_pipe [LAT];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk_in) begin
        if (mem_we_out) mem[mem_addr_out] <= mem_data_out;
        if (pl_en) mem[pl_addr] <= pl_data;
        rd_pipe[0] <= mem[mem_addr_out];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data_in = rd_pipe[LAT-1];

    typedef struct {
        int unsigned   port;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mem_val;
        logic [NP-1:0] exp_resp;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(input int unsigned p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid_in[p]       = 1'b1;
        req_we_in[p]          = we;
        req_addr_in[p*AW +: AW] = a;
        req_data_in[p*DW +: DW] = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic reset_dut();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NP-1:0] seen_resp;
        logic          seen_we;

        vecs[0] = '{port: 2, addr: 13'h123,  we: 1'b0, wdata: 8'h00, mem_val: 8'hAB, exp_resp: 4'b0100, exp_rdata: 8'hAB};
        vecs[1] = '{port: 0, addr: 13'h1FFF, we: 1'b0, wdata: 8'h00, mem_val: 8'h11, exp_resp: 4'b0001, exp_rdata: 8'h11};
        vecs[2] = '{port: 3, addr: 13'h0000, we: 1'b1, wdata: 8'hC3, mem_val: 8'h00, exp_resp: 4'b1000, exp_rdata: 8'h00};
        vecs[3] = '{port: 1, addr: 13'h0AA,  we: 1'b0, wdata: 8'h00, mem_val: 8'hFF, exp_resp: 4'b0010, exp_rdata: 8'hFF};

        rst_in = 1'b0; req_valid_in = '0; req_we_in = '0; req_addr_in = '0; req_data_in = '0;
        #2 rst_in = 1'b1;
        #1;
        chk("rst_ready",     32'(req_ready_out),  32'hF);
        chk("rst_resp",      32'(resp_valid_out), 32'h0);
        chk("rst_mem_we",    32'(mem_we_out),     32'h0);
        chk("rst_mem_addr",  32'(mem_addr_out),   32'h0);
        chk("rst_mem_data",  32'(mem_data_out),   32'h0);
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        // Single uncontended transactions; last_grant differs each time.
        for (int v = 0; v < 4; v++) begin
            preload(vecs[v].addr, vecs[v].mem_val);
            set_req(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            tick();
            chk("tbl_ready_low", 32'(req_ready_out[vecs[v].port]), 32'h0);
            req_valid_in = '0;
            tick();
            chk("tbl_mem_addr", 32'(mem_addr_out), 32'(vecs[v].addr));
            chk("tbl_mem_we",   32'(mem_we_out),   32'(vecs[v].we));
            if (vecs[v].we) chk("tbl_mem_data", 32'(mem_data_out), 32'(vecs[v].wdata));
            chk("tbl_ready_back", 32'(req_ready_out), 32'hF);
            chk("tbl_resp_early", 32'(resp_valid_out), 32'h0);
            tick();
            chk("tbl_resp_early2", 32'(resp_valid_out), 32'h0);
            tick();
            chk("tbl_resp", 32'(resp_valid_out), 32'(vecs[v].exp_resp));
            if (!vecs[v].we) chk("tbl_rdata", 32'(resp_data_out), 32'(vecs[v].exp_rdata));
            tick();
            chk("tbl_resp_single", 32'(resp_valid_out), 32'h0);
        end

        // Contention after reset: grants 0,1,2,3 then responses in the same order.
        for (int i = 0; i < NP; i++) preload(AW'(32'h100 + i), DW'(32'h10 + i));
        reset_dut();
        for (int i = 0; i < NP; i++) set_req(i, 1'b0, AW'(32'h100 + i), '0);
        tick();
        req_valid_in = '0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j <= 4) chk("cont_addr", 32'(mem_addr_out), 32'h100 + j - 1);
            if (j >= 3) begin
                chk("cont_resp",  32'(resp_valid_out), 32'(1) << (j - 3));
                chk("cont_rdata", 32'(resp_data_out),  32'h10 + j - 3);
            end
        end
        tick();

        // Fairness: ports 0 and 3 held valid alternate every cycle.
        set_req(0, 1'b0, 13'h0A0, '0);
        set_req(3, 1'b0, 13'h0D3, '0);
        tick();
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("fair_addr", 32'(mem_addr_out), (j % 2 == 1) ? 32'h0A0 : 32'h0D3);
            if (j >= 3) chk("fair_resp", 32'(resp_valid_out), (j % 2 == 1) ? 32'h1 : 32'h8);
        end
        req_valid_in = '0;
        for (int j = 0; j < 6; j++) tick();

        // Write then read from port 1.
        preload(13'h010, 8'h00);
        set_req(1, 1'b1, 13'h010, 8'h5A);
        tick();
        chk("wr_ready_low", 32'(req_ready_out[1]), 32'h0);
        req_we_in[1] = 1'b0;
        tick();
        chk("wr_mem_we",   32'(mem_we_out),       32'h1);
        chk("wr_mem_addr", 32'(mem_addr_out),     32'h010);
        chk("wr_mem_data", 32'(mem_data_out),     32'h5A);
        chk("wr_ready",    32'(req_ready_out[1]), 32'h1);
        tick();
        req_valid_in = '0;
        chk("wr_idle_we",  32'(mem_we_out),       32'h0);
        chk("wr_idle_rsp", 32'(resp_valid_out),   32'h0);
        tick();
        chk("rd_mem_addr", 32'(mem_addr_out),     32'h010);
        chk("rd_mem_we",   32'(mem_we_out),       32'h0);
        chk("wr_resp",     32'(resp_valid_out),   32'h2);
        tick();
        chk("wr_resp_gap", 32'(resp_valid_out),   32'h0);
        tick();
        chk("rd_resp",     32'(resp_valid_out),   32'h2);
        chk("rd_rdata",    32'(resp_data_out),    32'h5A);
        tick();

        // Reset while operations are in flight and one port is still pending.
        reset_dut();
        set_req(1, 1'b0, 13'h055, 8'h00);
        set_req(2, 1'b0, 13'h066, 8'h99);
        set_req(3, 1'b0, 13'h077, 8'h00);
        tick();
        req_valid_in = '0;
        tick();
        chk("mf_addr1", 32'(mem_addr_out), 32'h055);
        tick();
        chk("mf_addr2",  32'(mem_addr_out),  32'h066);
        chk("mf_data2",  32'(mem_data_out),  32'h99);
        chk("mf_ready",  32'(req_ready_out), 32'h7);
        #2 rst_in = 1'b1;
        #1;
        chk("mf_rst_ready", 32'(req_ready_out),  32'hF);
        chk("mf_rst_addr",  32'(mem_addr_out),   32'h0);
        chk("mf_rst_data",  32'(mem_data_out),   32'h0);
        chk("mf_rst_we",    32'(mem_we_out),     32'h0);
        chk("mf_rst_resp",  32'(resp_valid_out), 32'h0);
        tick();
        rst_in = 1'b0;
        seen_resp = '0;
        seen_we   = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            seen_resp |= resp_valid_out;
            seen_we   |= mem_we_out;
        end
        chk("mf_no_resp",   32'(seen_resp),     32'h0);
        chk("mf_no_we",     32'(seen_we),       32'h0);
        chk("mf_no_issue",  32'(mem_addr_out),  32'h0);
        chk("mf_ready_end", 32'(req_ready_out), 32'hF);

        // Backpressure: port 0 held valid, ready drops for one cycle per acceptance.
        chk("bp_ready_pre", 32'(req_ready_out[0]), 32'h1);
        set_req(0, 1'b0, 13'h1AB, '0);
        tick();
        for (int j = 0; j < 6; j++) begin
            chk("bp_ready", 32'(req_ready_out[0]), (j % 2 == 0) ? 32'h0 : 32'h1);
            if (j >= 3) chk("bp_resp", 32'(resp_valid_out), (j % 2 == 1) ? 32'h1 : 32'h0);
            tick();
        end
        req_valid_in = '0;
        for (int j = 0; j < 5; j++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chip8_mem_arbiter.md
CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of requester ports, legal range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13: memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: data word width.
REQ-004 SHALL have parameter LATENCY, default 2: memory read latency in cycles, legal range 1..4.
REQ-005 SHALL have port clk_in  input  1  single clock for all logic.
REQ-006 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid_in  input  NUM_PORTS  per-port request valid.
REQ-008 SHALL have port req_ready_out  output  NUM_PORTS  per-port ready; a request transfers when valid and ready are both high at a clock edge.
REQ-009 SHALL have port req_addr_in  input  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port req_we_in  input  NUM_PORTS  per-port write enable.
REQ-011 SHALL have port req_data_in  input  NUM_PORTS*DATA_WIDTH  per-port write data, packed the same way as req_addr_in.
REQ-012 SHALL have port resp_valid_out  output  NUM_PORTS  one-hot completion strobe per port.
REQ-013 SHALL have port resp_data_out  output  DATA_WIDTH  read data; valid only when resp_valid_out is non-zero.
REQ-014 SHALL have port mem_addr_out  output  ADDR_WIDTH  registered memory address.
REQ-015 SHALL have port mem_we_out  output  1  registered memory write enable.
REQ-016 SHALL have port mem_data_out  output  DATA_WIDTH  registered memory write data.
REQ-017 SHALL have port mem_data_in  input  DATA_WIDTH  memory read data, valid LATENCY cycles after the address is driven.

Function
REQ-018 SHALL hold one pending slot per port (addr, we, data); req_ready_out[i] SHALL be the inverse of the pending[i] flag, with no combinational path from valid to ready.
REQ-019 SHALL set pending[i] and capture the request on the edge where req_valid_in[i] and req_ready_out[i] are both high.
REQ-020 SHALL pick one grant per cycle from the pending ports, round-robin: search starts at last_grant+1 and wraps modulo NUM_PORTS.
REQ-021 SHALL do the following on the edge ending a grant cycle: drive the granted entry onto mem_addr_out/mem_we_out/mem_data_out, clear its pending flag, and update last_grant.
REQ-022 SHALL drive mem_we_out=0 in a cycle after no grant; mem_addr_out and mem_data_out hold their previous values.
REQ-023 SHALL carry a tag {valid, port index} for each issued operation through a LATENCY-deep shift pipeline, with reads and writes treated the same.
REQ-024 SHALL assert resp_valid_out[p] for exactly one cycle when the tag exits the pipeline, i.e. LATENCY cycles after the operation is driven on mem_*; resp_data_out SHALL equal mem_data_in combinationally.
REQ-025 SHALL, for an uncontended request accepted at edge k, drive the operation on mem_* after edge k+1 and pulse resp_valid_out in cycle k+1+LATENCY.
REQ-026 SHALL allow a port to be ready again in the cycle its operation is driven; back-to-back issue from one port SHALL reach 1 request per 2 cycles.
REQ-027 SHALL bound the wait of a pending port to NUM_PORTS-1 grants to other ports.
REQ-028 SHALL keep responses in issue order, with at most one response per cycle.
REQ-029 SHALL treat a single pending port, with all others idle, as granted every time it is pending, whatever the value of last_grant.

Reset
REQ-030 SHALL, while rst_in is high and independent of the clock, force: pending=0 (so req_ready_out is all ones), last_grant=NUM_PORTS-1, tag pipeline empty, resp_valid_out=0, mem_we_out=0, mem_addr_out=0, mem_data_out=0.
REQ-031 SHALL drop operations in flight at reset: no resp_valid_out pulse for them after reset is released.
REQ-032 SHALL give port 0 priority on the first grant after reset.

Verification
REQ-033 SHALL cover a single read: port 2 reads addr 0x123, memory returns 0xAB -> mem_addr_out=0x123 one cycle after acceptance, resp_valid_out=4'b0100 with resp_data_out=0xAB LATENCY cycles later.
REQ-034 SHALL cover contention: all 4 ports request in the same cycle after reset -> grants go 0,1,2,3 on consecutive cycles, and resp_valid_out pulses in that order.
REQ-035 SHALL cover fairness: ports 0 and 3 request continuously -> grants alternate 3,0,3,0 after the first grant to 0, and neither port waits more than 1 grant.
REQ-036 SHALL cover a write then read: port 1 writes 0x5A to addr 0x010, then reads addr 0x010 -> mem_we_out=1 with mem_data_out=0x5A, a response pulse for the write, then the read response returns 0x5A.
REQ-037 SHALL cover reset mid-flight: rst_in asserted one cycle after a read issues -> all outputs at reset values at once, and no resp_valid_out after release.
REQ-038 SHALL cover backpressure: port 0 holds valid high -> req_ready_out[0] low for exactly 1 cycle per accepted request when uncontended.
